// File: rtl/pe_array_feeder.sv
// rtl/pe_array_feeder.sv - tile loader, interleaved streamer and psum collector for PE_array
//
// Purpose: buffers NPAIR weight and NPAIR activation words, pulses the PE_array
// active-low reset for one cycle, streams W0,A0,W1,A1,... on pe_data_out, samples
// the three row psums at fixed offsets after the last word, and returns them one
// per handshake on the result port.
//
// Ports:
//   clk_in, rst_in                       clock / async active-low reset
//   w_valid_in, w_ready_out, w_data_in   weight word input handshake
//   a_valid_in, a_ready_out, a_data_in   activation word input handshake
//   pe_rst_out, pe_data_out              PE_array reset and data stream
//   psum_row_0_in..psum_row_2_in         PE_array row psums
//   res_valid_out, res_ready_in,
//   res_data_out, res_row_out            captured psum result handshake
//   busy_out                             high outside LOAD
module pe_array_feeder #(
    parameter int WORD_W  = 27,
    parameter int PSUM_W  = 14,
    parameter int NPAIR   = 6,
    parameter int LAT     = 3,
    parameter int ROW_GAP = 2
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              w_valid_in,
    output logic              w_ready_out,
    input  logic [WORD_W-1:0] w_data_in,
    input  logic              a_valid_in,
    output logic              a_ready_out,
    input  logic [WORD_W-1:0] a_data_in,
    output logic              pe_rst_out,
    output logic [WORD_W-1:0] pe_data_out,
    input  logic [PSUM_W-1:0] psum_row_0_in,
    input  logic [PSUM_W-1:0] psum_row_1_in,
    input  logic [PSUM_W-1:0] psum_row_2_in,
    output logic              res_valid_out,
    input  logic              res_ready_in,
    output logic [PSUM_W-1:0] res_data_out,
    output logic [1:0]        res_row_out,
    output logic              busy_out
);

    localparam int CW = $clog2(2*NPAIR+1);
    localparam int TW = $clog2(LAT+2*ROW_GAP+1);
    localparam int IW = (NPAIR > 1) ? $clog2(NPAIR) : 1;

    localparam logic [CW-1:0] CNT_FULL = CW'(NPAIR);
    localparam logic [CW-1:0] S_LAST   = CW'(2*NPAIR-1);
    localparam logic [TW-1:0] T_ROW0   = TW'(LAT);
    localparam logic [TW-1:0] T_ROW1   = TW'(LAT+ROW_GAP);
    localparam logic [TW-1:0] T_ROW2   = TW'(LAT+2*ROW_GAP);

    typedef enum logic [2:0] {
        S_LOAD,
        S_PRST,
        S_STREAM,
        S_DRAIN,
        S_OUT
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CW-1:0]     r_w_cnt, r_a_cnt, r_s;
    logic [CW-1:0]     w_w_cnt_nxt, w_a_cnt_nxt, w_s_nxt;
    logic [TW-1:0]     r_t, w_t_nxt;
    logic [1:0]        r_row;
    logic [PSUM_W-1:0] r_cap0, r_cap1, r_cap2;
    logic [WORD_W-1:0] r_wbuf [NPAIR];
    logic [WORD_W-1:0] r_abuf [NPAIR];

    logic              r_w_ready, r_a_ready, r_pe_rst, r_res_valid, r_busy;
    logic [WORD_W-1:0] r_pe_data, w_word_nxt;
    logic [PSUM_W-1:0] r_res_data;
    logic [IW-1:0]     w_idx;
    logic              w_w_acc, w_a_acc, w_res_hs;

    // Readies are registered and already 0 outside LOAD, so a valid there is ignored.
    assign w_w_acc  = r_w_ready && w_valid_in;
    assign w_a_acc  = r_a_ready && a_valid_in;
    assign w_res_hs = r_res_valid && res_ready_in;

    always_comb begin
        w_state_nxt = r_state;
        w_w_cnt_nxt = r_w_cnt;
        w_a_cnt_nxt = r_a_cnt;
        w_s_nxt     = r_s;
        w_t_nxt     = r_t;
        case (r_state)
            S_LOAD: begin
                if (w_w_acc) w_w_cnt_nxt = r_w_cnt + 1'b1;
                if (w_a_acc) w_a_cnt_nxt = r_a_cnt + 1'b1;
                if (r_w_cnt == CNT_FULL && r_a_cnt == CNT_FULL) w_state_nxt = S_PRST;
            end
            S_PRST: begin
                w_s_nxt     = '0;
                w_state_nxt = S_STREAM;
            end
            S_STREAM: begin
                w_s_nxt = r_s + 1'b1;
                w_t_nxt = TW'(1);
                if (r_s == S_LAST) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                w_t_nxt = r_t + 1'b1;
                if (r_t == T_ROW2) w_state_nxt = S_OUT;
            end
            S_OUT: begin
                if (w_res_hs && r_row == 2'd2) begin
                    w_state_nxt = S_LOAD;
                    w_w_cnt_nxt = '0;
                    w_a_cnt_nxt = '0;
                end
            end
            default: w_state_nxt = S_LOAD;
        endcase
    end

    // The word shown during stream step s is registered on the edge entering that step,
    // so the lookup uses the next step index; even steps are weights, odd activations.
    always_comb begin
        w_idx      = IW'(w_s_nxt >> 1);
        w_word_nxt = '0;
        if (w_state_nxt == S_STREAM) begin
            w_word_nxt = w_s_nxt[0] ? r_abuf[w_idx] : r_wbuf[w_idx];
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_w_acc) r_wbuf[IW'(r_w_cnt)] <= w_data_in;
        if (w_a_acc) r_abuf[IW'(r_a_cnt)] <= a_data_in;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state     <= S_LOAD;
            r_w_cnt     <= '0;
            r_a_cnt     <= '0;
            r_s         <= '0;
            r_t         <= '0;
            r_row       <= '0;
            r_cap0      <= '0;
            r_cap1      <= '0;
            r_cap2      <= '0;
            r_w_ready   <= 1'b0;
            r_a_ready   <= 1'b0;
            r_pe_rst    <= 1'b0;
            r_pe_data   <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_w_cnt   <= w_w_cnt_nxt;
            r_a_cnt   <= w_a_cnt_nxt;
            r_s       <= w_s_nxt;
            r_t       <= w_t_nxt;
            r_w_ready <= (w_state_nxt == S_LOAD) && (w_w_cnt_nxt < CNT_FULL);
            r_a_ready <= (w_state_nxt == S_LOAD) && (w_a_cnt_nxt < CNT_FULL);
            r_pe_rst  <= (w_state_nxt != S_PRST);
            r_busy    <= (w_state_nxt != S_LOAD);
            r_pe_data <= w_word_nxt;

            if (r_state == S_DRAIN) begin
                if (r_t == T_ROW0) r_cap0 <= psum_row_0_in;
                if (r_t == T_ROW1) r_cap1 <= psum_row_1_in;
                if (r_t == T_ROW2) r_cap2 <= psum_row_2_in;
            end

            // cap0 is already settled when DRAIN ends, so row 0 can be presented at once.
            if (r_state == S_DRAIN && w_state_nxt == S_OUT) begin
                r_res_valid <= 1'b1;
                r_row       <= 2'd0;
                r_res_data  <= r_cap0;
            end else if (w_res_hs) begin
                if (r_row == 2'd2) begin
                    r_res_valid <= 1'b0;
                    r_row       <= 2'd0;
                    r_res_data  <= '0;
                end else begin
                    r_row      <= r_row + 1'b1;
                    r_res_data <= (r_row == 2'd0) ? r_cap1 : r_cap2;
                end
            end
        end
    end

    assign w_ready_out   = r_w_ready;
    assign a_ready_out   = r_a_ready;
    assign pe_rst_out    = r_pe_rst;
    assign pe_data_out   = r_pe_data;
    assign res_valid_out = r_res_valid;
    assign res_data_out  = r_res_data;
    assign res_row_out   = r_row;
    assign busy_out      = r_busy;

endmodule

// File: tb/tb_pe_array_feeder.sv
// tb/tb_pe_array_feeder.sv - self-checking bench for pe_array_feeder
module tb_pe_array_feeder;

    localparam int NPAIR   = 6;
    localparam int LAT     = 3;
    localparam int ROW_GAP = 2;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        w_valid_in = 1'b0;
    logic        w_ready_out;
    logic [26:0] w_data_in = '0;
    logic        a_valid_in = 1'b0;
    logic        a_ready_out;
    logic [26:0] a_data_in = '0;
    logic        pe_rst_out;
    logic [26:0] pe_data_out;
    logic [13:0] psum_row_0_in = '0;
    logic [13:0] psum_row_1_in = '0;
    logic [13:0] psum_row_2_in = '0;
    logic        res_valid_out;
    logic        res_ready_in = 1'b0;
    logic [13:0] res_data_out;
    logic [1:0]  res_row_out;
    logic        busy_out;

    int n_checks = 0;
    int n_pass   = 0;

    logic [26:0] wexp [NPAIR];
    logic [26:0] aexp [NPAIR];
    logic [13:0] pval [3];

    pe_array_feeder dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .w_valid_in    (w_valid_in),
        .w_ready_out   (w_ready_out),
        .w_data_in     (w_data_in),
        .a_valid_in    (a_valid_in),
        .a_ready_out   (a_ready_out),
        .a_data_in     (a_data_in),
        .pe_rst_out    (pe_rst_out),
        .pe_data_out   (pe_data_out),
        .psum_row_0_in (psum_row_0_in),
        .psum_row_1_in (psum_row_1_in),
        .psum_row_2_in (psum_row_2_in),
        .res_valid_out (res_valid_out),
        .res_ready_in  (res_ready_in),
        .res_data_out  (res_data_out),
        .res_row_out   (res_row_out),
        .busy_out      (busy_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic random_psums();
        psum_row_0_in = 14'($urandom);
        psum_row_1_in = 14'($urandom);
        psum_row_2_in = 14'($urandom);
    endtask

    task automatic random_tile();
        for (int i = 0; i < NPAIR; i++) begin
            wexp[i] = 27'($urandom);
            aexp[i] = 27'($urandom);
        end
        for (int n = 0; n < 3; n++) pval[n] = 14'($urandom);
    endtask

    task automatic test_reset();
        @(negedge clk_in);
        #3;
        rst_in       = 1'b0;
        w_valid_in   = 1'b0;
        a_valid_in   = 1'b0;
        res_ready_in = 1'b0;
        #1;
        n_checks++;
        if ({pe_rst_out, pe_data_out, res_valid_out, res_data_out, res_row_out, busy_out,
             w_ready_out, a_ready_out} !== '0)
            $display("FAIL reset_outputs: got rst=%b data=%h rv=%b rd=%h row=%0d busy=%b wr=%b ar=%b want all 0",
                     pe_rst_out, pe_data_out, res_valid_out, res_data_out, res_row_out, busy_out,
                     w_ready_out, a_ready_out);
        else n_pass++;
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        n_checks++;
        if ({w_ready_out, a_ready_out, pe_rst_out, busy_out} !== 4'b1110)
            $display("FAIL reset_release: got wr=%b ar=%b pe_rst=%b busy=%b want 1 1 1 0",
                     w_ready_out, a_ready_out, pe_rst_out, busy_out);
        else n_pass++;
    endtask

    // mode 0 offers W and A together every cycle; mode 1 offers each with random gaps.
    task automatic load_tile(input int mode, input int w_start);
        int wi  = w_start;
        int ai  = 0;
        int cyc = 0;
        while ((wi < NPAIR || ai < NPAIR) && cyc < 400) begin
            @(negedge clk_in);
            cyc++;
            random_psums();
            w_valid_in = (wi < NPAIR) && (mode == 0 || $urandom_range(0, 1) == 1);
            a_valid_in = (ai < NPAIR) && (mode == 0 || $urandom_range(0, 1) == 1);
            w_data_in  = 27'($urandom);
            a_data_in  = 27'($urandom);
            if (wi < NPAIR) w_data_in = wexp[wi];
            if (ai < NPAIR) a_data_in = aexp[ai];
            if (w_valid_in && w_ready_out) wi++;
            if (a_valid_in && a_ready_out) ai++;
        end
        @(negedge clk_in);
        w_valid_in = 1'b0;
        a_valid_in = 1'b0;
        n_checks++;
        if (wi != NPAIR || ai != NPAIR)
            $display("FAIL load_timeout: accepted w=%0d a=%0d want %0d each", wi, ai, NPAIR);
        else n_pass++;
    endtask

    // Checks the PRST pulse and the 12-word stream, then drives the drain window with the
    // wanted psum only on its own sampling cycle and noise on every other cycle.
    task automatic run_stream(input int stop_at);
        int cyc = 0;
        logic [26:0] exp_word;
        while (pe_rst_out !== 1'b0 && cyc < 100) begin
            @(negedge clk_in);
            random_psums();
            cyc++;
        end
        n_checks++;
        if (pe_rst_out !== 1'b0 || busy_out !== 1'b1 || w_ready_out !== 1'b0)
            $display("FAIL prst_pulse: got pe_rst=%b busy=%b wr=%b want 0 1 0", pe_rst_out, busy_out, w_ready_out);
        else n_pass++;
        for (int j = 0; j < 2*NPAIR; j++) begin
            @(negedge clk_in);
            random_psums();
            exp_word = (j % 2 == 1) ? aexp[j/2] : wexp[j/2];
            n_checks++;
            if (pe_data_out !== exp_word || pe_rst_out !== 1'b1)
                $display("FAIL stream_word_%0d: got %h rst=%b want %h rst=1", j, pe_data_out, pe_rst_out, exp_word);
            else n_pass++;
            if (j == stop_at) return;
        end
        for (int t = 1; t <= LAT + 2*ROW_GAP; t++) begin
            @(negedge clk_in);
            random_psums();
            if (t == LAT)             psum_row_0_in = pval[0];
            if (t == LAT + ROW_GAP)   psum_row_1_in = pval[1];
            if (t == LAT + 2*ROW_GAP) psum_row_2_in = pval[2];
            n_checks++;
            if (pe_data_out !== 27'h0 || res_valid_out !== 1'b0)
                $display("FAIL drain_t%0d: got data=%h rv=%b want 0 0", t, pe_data_out, res_valid_out);
            else n_pass++;
        end
    endtask

    task automatic collect(input int stall);
        res_ready_in = 1'b0;
        for (int k = 0; k < stall; k++) begin
            @(negedge clk_in);
            random_psums();
            n_checks++;
            if (res_valid_out !== 1'b1 || res_row_out !== 2'd0 || res_data_out !== pval[0])
                $display("FAIL stall_%0d: got rv=%b row=%0d data=%h want 1 0 %h",
                         k, res_valid_out, res_row_out, res_data_out, pval[0]);
            else n_pass++;
        end
        for (int r = 0; r < 3; r++) begin
            @(negedge clk_in);
            random_psums();
            n_checks++;
            if (res_valid_out !== 1'b1 || res_row_out !== 2'(r) || res_data_out !== pval[r])
                $display("FAIL result_row%0d: got rv=%b row=%0d data=%h want 1 %0d %h",
                         r, res_valid_out, res_row_out, res_data_out, r, pval[r]);
            else n_pass++;
            res_ready_in = 1'b1;
        end
        @(negedge clk_in);
        res_ready_in = 1'b0;
        n_checks++;
        if (res_valid_out !== 1'b0 || busy_out !== 1'b0 || w_ready_out !== 1'b1 || a_ready_out !== 1'b1)
            $display("FAIL back_to_load: got rv=%b busy=%b wr=%b ar=%b want 0 0 1 1",
                     res_valid_out, busy_out, w_ready_out, a_ready_out);
        else n_pass++;
    endtask

    task automatic test_basic_tile();
        for (int i = 0; i < NPAIR; i++) begin
            wexp[i] = 27'(i + 1);
            aexp[i] = 27'(32'h100 + i);
        end
        for (int n = 0; n < 3; n++) pval[n] = 14'(14'h0AA + n);
        load_tile(0, 0);
        run_stream(-1);
        collect(5);
    endtask

    task automatic test_w_overflow();
        random_tile();
        for (int i = 0; i < NPAIR; i++) wexp[i] = 27'(i + 1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_in);
            w_valid_in = 1'b1;
            w_data_in  = 27'(i + 1);
            n_checks++;
            if (w_ready_out !== (i < NPAIR))
                $display("FAIL w_ovf_ready_%0d: got %b want %b", i, w_ready_out, (i < NPAIR));
            else n_pass++;
        end
        @(negedge clk_in);
        w_valid_in = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_in);
            n_checks++;
            if (pe_rst_out !== 1'b1 || busy_out !== 1'b0 || a_ready_out !== 1'b1)
                $display("FAIL w_ovf_wait_%0d: got pe_rst=%b busy=%b ar=%b want 1 0 1",
                         k, pe_rst_out, busy_out, a_ready_out);
            else n_pass++;
        end
        load_tile(1, NPAIR);
        run_stream(-1);
        collect(0);
    endtask

    task automatic test_reset_mid_stream();
        random_tile();
        load_tile(1, 0);
        run_stream(5);
        test_reset();
        random_tile();
        load_tile(0, 0);
        run_stream(-1);
        collect(2);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 3; k++) begin
            random_tile();
            load_tile(1, 0);
            run_stream(-1);
            collect($urandom_range(0, 3));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_tile();
        test_w_overflow();
        test_reset_mid_stream();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
